// File: rtl/mem_port_arbiter_pkg.sv
// Shared sizes and encodings for the fetch/data memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int DATA_SIZE = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory handshake bundle around the shared memory port.
// slave = arbiter view; master = pipeline plus memory model view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int AddrSize = ADDR_SIZE,
  parameter int DataSize = DATA_SIZE
);

  logic                  if_req_i;
  logic [AddrSize-1:0]   if_addr_i;
  logic [DataSize-1:0]   if_rdata_o;
  logic                  if_ready_o;
  logic                  if_err_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [DataSize/8-1:0] d_be_i;
  logic [AddrSize-1:0]   d_addr_i;
  logic [DataSize-1:0]   d_wdata_i;
  logic [DataSize-1:0]   d_rdata_o;
  logic                  d_ready_o;
  logic                  d_err_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [DataSize/8-1:0] mem_be_o;
  logic [AddrSize-1:0]   mem_addr_o;
  logic [DataSize-1:0]   mem_wdata_o;
  logic [DataSize-1:0]   mem_rdata_i;
  logic                  mem_ack_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ready_o, if_err_o,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output d_rdata_o, d_ready_o, d_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ready_o, if_err_o,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  d_rdata_o, d_ready_o, d_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Data-first arbiter for the single memory port: request-to-ready >= 2 cycles, 3-cycle issue interval.
// Requesters hold req until their one-cycle ready; a missing ack closes the transaction with err after Timeout cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AddrSize = ADDR_SIZE,
  parameter int DataSize = DATA_SIZE,
  parameter int Timeout  = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam logic [7:0] TimeoutLast = 8'(Timeout - 1);

  arb_state_e            state_q, state_d;
  logic                  owner_q;
  logic [7:0]            wait_cnt_q;

  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [DataSize/8-1:0] mem_be_q;
  logic [AddrSize-1:0]   mem_addr_q;
  logic [DataSize-1:0]   mem_wdata_q;

  logic [DataSize-1:0]   if_rdata_q, d_rdata_q;
  logic                  if_ready_q, d_ready_q;
  logic                  if_err_q, d_err_q;

  logic                  ack_hit;
  logic                  expired;
  logic                  finish;
  logic [DataSize-1:0]   cap_rdata;

  always_comb begin
    state_d   = state_q;
    ack_hit   = 1'b0;
    expired   = 1'b0;
    finish    = 1'b0;
    cap_rdata = '0;
    case (state_q)
      ARB_IDLE: begin
        if (bus.d_req_i || bus.if_req_i) state_d = ARB_BUSY;
      end
      ARB_BUSY: begin
        // An ack landing in the last allowed cycle beats the timeout.
        ack_hit = bus.mem_ack_i;
        expired = !bus.mem_ack_i && (wait_cnt_q == TimeoutLast);
        finish  = ack_hit || expired;
        if (ack_hit && !mem_we_q) cap_rdata = bus.mem_rdata_i;
        if (finish) state_d = ARB_DONE;
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      wait_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          wait_cnt_q <= '0;
          if (bus.d_req_i) begin
            owner_q     <= OWN_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we_i;
            mem_be_q    <= bus.d_be_i;
            mem_addr_q  <= bus.d_addr_i;
            mem_wdata_q <= bus.d_wdata_i;
          end else if (bus.if_req_i) begin
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '1;
            mem_addr_q  <= bus.if_addr_i;
            mem_wdata_q <= '0;
          end
        end
        ARB_BUSY: begin
          if (finish) begin
            mem_req_q <= 1'b0;
            if (owner_q == OWN_D) begin
              d_rdata_q <= cap_rdata;
              d_err_q   <= expired;
              d_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= cap_rdata;
              if_err_q   <= expired;
              if_ready_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.if_ready_o  = if_ready_q;
  assign bus.if_err_o    = if_err_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.d_ready_o   = d_ready_q;
  assign bus.d_err_o     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random transactions against a
// transaction-level model (grant order, ack delay -> expected req window, ready cycle, err, rdata).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.AddrSize(AW), .DataSize(DW)) bus ();

  mem_port_arbiter #(.AddrSize(AW), .DataSize(DW), .Timeout(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  bit          if_pend, d_pend, hold_if;
  logic [31:0] if_addr, d_addr, d_wdata;
  bit          d_we;
  logic [3:0]  d_be;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    bus.if_req_i  = if_pend;
    bus.if_addr_i = if_addr;
    bus.d_req_i   = d_pend;
    bus.d_we_i    = d_we;
    bus.d_be_i    = d_be;
    bus.d_addr_i  = d_addr;
    bus.d_wdata_i = d_wdata;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_mem_req"}, bus.mem_req_o, 0);
    check_val({tag, "_if_ready"}, bus.if_ready_o, 0);
    check_val({tag, "_d_ready"}, bus.d_ready_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check_val({tag, "_mem_we"}, bus.mem_we_o, 0);
    check_val({tag, "_mem_be"}, bus.mem_be_o, 0);
    check_val({tag, "_mem_addr"}, bus.mem_addr_o, 0);
    check_val({tag, "_mem_wdata"}, bus.mem_wdata_o, 0);
    check_val({tag, "_if_rdata"}, bus.if_rdata_o, 0);
    check_val({tag, "_d_rdata"}, bus.d_rdata_o, 0);
    check_val({tag, "_if_err"}, bus.if_err_o, 0);
    check_val({tag, "_d_err"}, bus.d_err_o, 0);
  endtask

  // Called in an IDLE cycle with at least one request driven. dly = cycle of the ack
  // after the grant (> TO means the memory never answers within the window).
  task automatic run_txn(input int dly, input logic [31:0] rdat);
    bit          win_d;
    int          e;
    bit          err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    bit          exp_we;
    logic [3:0]  exp_be;
    win_d     = d_pend;
    e         = (dly <= TO) ? dly : TO;
    err       = (dly > TO);
    exp_addr  = win_d ? d_addr : if_addr;
    exp_we    = win_d ? d_we : 1'b0;
    exp_be    = win_d ? d_be : 4'hf;
    exp_wdata = win_d ? d_wdata : 32'h0;
    exp_rdata = (err || exp_we) ? 32'h0 : rdat;
    bus.mem_ack_i   = 1'($urandom_range(0, 1));
    bus.mem_rdata_i = $urandom;
    for (int t = 1; t <= e + 1; t++) begin
      step();
      check_val("mem_req", bus.mem_req_o, (t <= e));
      if (t <= e) begin
        check_val("mem_addr", bus.mem_addr_o, exp_addr);
        check_val("mem_we", bus.mem_we_o, exp_we);
        check_val("mem_be", bus.mem_be_o, exp_be);
        check_val("mem_wdata", bus.mem_wdata_o, exp_wdata);
      end
      check_val("if_ready", bus.if_ready_o, (t == e + 1) && !win_d);
      check_val("d_ready", bus.d_ready_o, (t == e + 1) && win_d);
      if (t == e + 1) begin
        if (win_d) begin
          check_val("d_rdata", bus.d_rdata_o, exp_rdata);
          check_val("d_err", bus.d_err_o, err);
        end else begin
          check_val("if_rdata", bus.if_rdata_o, exp_rdata);
          check_val("if_err", bus.if_err_o, err);
        end
      end
      bus.mem_ack_i   = (t == dly) || (t == e + 1 && $urandom_range(0, 3) == 0);
      bus.mem_rdata_i = (t == dly) ? rdat : $urandom;
      if (t == e + 1) begin
        if (win_d) d_pend = 1'b0;
        else if_pend = hold_if;
        drive_reqs();
      end
    end
    step();
    bus.mem_ack_i = 1'b0;
    check_quiet("idle_after_done");
  endtask

  task automatic new_fetch(input logic [31:0] a);
    if_pend = 1'b1;
    if_addr = a;
  endtask

  task automatic new_data(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    d_pend  = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_be    = be;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    if_pend = 0; d_pend = 0; hold_if = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; d_we = 0; d_be = 0;
    rst = 1'b1;
    drive_reqs();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Single fetch, ack two cycles after grant.
    new_fetch(32'h10);
    drive_reqs();
    run_txn(2, 32'hDEADBEEF);

    // Simultaneous requests: data write first, then the held fetch.
    new_data(1'b1, 32'h20, 32'h12345678, 4'hf);
    new_fetch(32'h04);
    drive_reqs();
    run_txn(1, 32'hAAAA5555);
    run_txn(1, 32'hCAFEF00D);

    // Timeout on a data read, then a normal fetch.
    new_data(1'b0, 32'h30, 32'h0, 4'h3);
    drive_reqs();
    run_txn(TO + 3, 32'h11111111);
    new_fetch(32'h40);
    drive_reqs();
    run_txn(1, 32'h0BADC0DE);

    // Ack exactly on the timeout cycle.
    new_data(1'b0, 32'h50, 32'h0, 4'hc);
    drive_reqs();
    run_txn(TO, 32'h76543210);

    // Fetch request held high across ready: two separate transactions.
    hold_if = 1'b1;
    new_fetch(32'h60);
    drive_reqs();
    run_txn(3, 32'h01020304);
    hold_if = 1'b0;
    run_txn(1, 32'h05060708);

    // Reset while BUSY abandons the transaction.
    new_fetch(32'h70);
    drive_reqs();
    step();
    check_val("rst_pre_mem_req", bus.mem_req_o, 1);
    step();
    rst = 1'b1;
    step();
    check_all_zero("rst_mid");
    rst = 1'b0;
    if_pend = 1'b0;
    drive_reqs();
    repeat (3) begin
      step();
      check_quiet("rst_after");
    end
    new_fetch(32'h74);
    drive_reqs();
    run_txn(2, 32'h13572468);

    // Random traffic.
    repeat (400) begin
      if (!if_pend && $urandom_range(0, 1) == 1) new_fetch($urandom);
      if (!d_pend && $urandom_range(0, 2) == 0)
        new_data(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      hold_if = ($urandom_range(0, 3) == 0);
      drive_reqs();
      if (if_pend || d_pend) begin
        run_txn($urandom_range(1, TO + 2), $urandom);
      end else begin
        bus.mem_ack_i = 1'($urandom_range(0, 1));
        step();
        bus.mem_ack_i = 1'b0;
        check_quiet("idle");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the pipeline's single memory port between the instruction-fetch stage and the data-memory stage. Each requester issues one transaction at a time. The arbiter grants data-stage requests first, drives the external memory handshake, and returns a one-cycle ready pulse with read data. A per-transaction timeout closes the transaction with an error flag if the memory never acknowledges. The block sits between `pipeline` and the memory model/controller and is driven from `defines.vh` sizes.

## Interface
- AddrSize, `ADDR_SIZE, address width of both requesters and the memory port
- DataSize, 32, data word width
- Timeout, 15, maximum cycles in BUSY waiting for `mem_ack_i`; range 1..255
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset; synchronous and active-high
- if_req_i  in  1  fetch request, held until `if_ready_o`
- if_addr_i  in  AddrSize  fetch address
- if_rdata_o  out  DataSize  fetched word, valid with `if_ready_o`
- if_ready_o  out  1  one-cycle completion pulse
- if_err_o  out  1  timeout flag, valid with `if_ready_o`
- d_req_i  in  1  data request, held until `d_ready_o`
- d_we_i  in  1  1 = write, 0 = read
- d_be_i  in  DataSize/8  byte enables
- d_addr_i  in  AddrSize  data address
- d_wdata_i  in  DataSize  write data
- d_rdata_o  out  DataSize  read data, valid with `d_ready_o`
- d_ready_o  out  1  one-cycle completion pulse
- d_err_o  out  1  timeout flag, valid with `d_ready_o`
- mem_req_o  out  1  memory request, held until ack or timeout
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/DataSize/8/AddrSize/DataSize  registered copy of the granted request
- mem_rdata_i  in  DataSize  memory read data, sampled on the ack cycle
- mem_ack_i  in  1  one-cycle acknowledge

## Operation
- FSM states: IDLE, BUSY, DONE; `owner` register: 0 = fetch, 1 = data.
- IDLE:
  - If `d_req_i`, grant data. Otherwise, if `if_req_i`, grant fetch.
  - On a grant, latch addr/we/be/wdata into the `mem_*` registers and go to BUSY.
  - A fetch grant forces `mem_we_o` = 0 and `mem_be_o` = all ones.
- BUSY:
  - `mem_req_o` = 1.
  - On `mem_ack_i`: capture `mem_rdata_i` into the owner's rdata register, err = 0, go to DONE.
  - Otherwise increment `wait_cnt`. When `wait_cnt` == Timeout−1 with no ack: rdata = 0, err = 1, go to DONE.
  - Ack in the timeout cycle wins (err = 0).
- DONE:
  - The owner's ready is asserted for exactly one cycle, and the owner's err is valid.
  - `mem_req_o` = 0.
  - The next state is always IDLE, so a requester that drops or renews its request after ready is never double-granted.
- Writes return rdata = 0.
- Requests arriving while the arbiter is not in IDLE wait; they are not queued.
- Fetch starvation is bounded by the pipeline: a pending data request stalls the pipeline, so data requests cannot back-to-back indefinitely.
- `mem_ack_i` outside BUSY is ignored.
- Reset clears all state:
  - State = IDLE, `wait_cnt` = 0.
  - All outputs = 0, including `mem_*` payload, rdata registers, ready and err.
  - An in-flight transaction is abandoned: `mem_req_o` falls on the cycle after the reset edge, and no ready pulse is produced for it.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Cycle 0: request seen in IDLE. Cycle 1: `mem_req_o` = 1 with payload. Ack in cycle k ≥ 1 → ready in cycle k+1 → IDLE in cycle k+2.
- Minimum request-to-ready latency is 2 cycles; minimum issue interval is 3 cycles per transaction.
- Timeout case: `mem_req_o` is high for Timeout cycles (1..Timeout), then ready + err in cycle Timeout+1.
- `wait_cnt` is 8 bits, cleared on entry to BUSY, and never wraps.

## Structure
- Shared package (`defines.vh` or a package beside it):
  - ADDR_SIZE, DATA_SIZE.
  - State encodings: ARB_IDLE = 2'd0, ARB_BUSY = 2'd1, ARB_DONE = 2'd2.
  - Owner encodings: OWN_IF = 1'b0, OWN_D = 1'b1.
- One module. No sub-module is needed, though the timeout counter may be factored as `arb_timeout_cnt` if reused by other port controllers.

## Test plan
- Single fetch: `if_req_i` = 1, addr 0x10; memory acks in cycle 2 with 0xDEADBEEF → `mem_addr_o` = 0x10, `mem_we_o` = 0, `if_ready_o` in cycle 3 with `if_rdata_o` = 0xDEADBEEF, `if_err_o` = 0; `d_ready_o` never set.
- Simultaneous requests: `d_req_i` write 0x20/0x12345678 (be = 4'b1111) and `if_req_i` 0x04 in the same cycle, ack latency 1 → data transaction first (`mem_we_o` = 1, `mem_wdata_o` = 0x12345678), `d_ready_o` in cycle 2; fetch is granted in cycle 3 (IDLE) and `if_ready_o` follows in cycle 5.
- Timeout: Timeout = 4, data read, no ack → `mem_req_o` high in cycles 1–4, `d_ready_o` = 1 with `d_err_o` = 1 and `d_rdata_o` = 0 in cycle 5; the next request proceeds normally.
- Ack on the timeout boundary: Timeout = 4, ack in cycle 4 → err = 0 and rdata is captured.
- Reset mid-op: `rst_i` during BUSY → `mem_req_o` = 0 and all outputs zero the next cycle; no ready pulse; a subsequent fetch completes normally.
- Back-to-back fetches with a held request: `if_req_i` kept high across ready → exactly one ready pulse per transaction, with grants separated by the DONE cycle.
